// File: rtl/mm_prog_loader.sv
// Byte-stream program loader: hunts for SYNC, assembles little-endian words from the
// payload, writes them to core memory and checks the trailing mod-256 payload sum.
//
// state   | meaning
// S_IDLE  | hunting for SYNC, non-SYNC bytes dropped
// S_LEN   | waiting for the word count
// S_DATA  | collecting the four bytes of the next word
// S_WRITE | one-cycle memory write, byte input stalled
// S_CSUM  | waiting for the checksum byte
module mm_prog_loader #(
    parameter int         DEPTH     = 128,
    parameter int         ADDR_W    = 7,
    parameter logic [7:0] SYNC      = 8'hA5,
    parameter int         TIMEOUT   = 1024,
    parameter bit         BOOT_HOLD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int             TW       = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [8:0]     DEPTH_L  = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM
    } state_t;

    state_t            state_q, state_nx;
    logic [ADDR_W:0]   len_q, len_nx;
    logic [1:0]        idx_q, idx_nx;
    logic [31:0]       word_q, word_nx;
    logic [7:0]        csum_q, csum_nx;
    logic [TW-1:0]     tmo_q, tmo_nx;
    logic [ADDR_W:0]   cnt_q, cnt_nx, cnt_inc;
    logic              err_q, err_nx;
    logic              done_q, done_nx;
    logic              crst_q, crst_nx;
    logic              accept;

    assign rx_ready  = (state_q != S_WRITE);
    assign accept    = rx_valid && rx_ready;
    assign cnt_inc   = cnt_q + (ADDR_W+1)'(1);

    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = cnt_q[ADDR_W-1:0];
    assign mem_wdata = word_q;
    assign core_rst  = crst_q;
    assign load_busy = (state_q != S_IDLE);
    assign load_done = done_q;
    assign load_err  = err_q;
    assign word_cnt  = cnt_q;

    always_comb begin
        state_nx = state_q;
        len_nx   = len_q;
        idx_nx   = idx_q;
        word_nx  = word_q;
        csum_nx  = csum_q;
        tmo_nx   = tmo_q;
        cnt_nx   = cnt_q;
        err_nx   = err_q;
        done_nx  = 1'b0;
        crst_nx  = crst_q;

        case (state_q)
            S_IDLE: begin
                tmo_nx = '0;
                if (accept && rx_data == SYNC) begin
                    err_nx   = 1'b0;
                    csum_nx  = 8'd0;
                    cnt_nx   = '0;
                    state_nx = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH_L) begin
                        err_nx   = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        len_nx   = (ADDR_W+1)'(rx_data);
                        crst_nx  = 1'b1;
                        idx_nx   = 2'd0;
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_nx[{idx_q, 3'b000} +: 8] = rx_data;
                    csum_nx = csum_q + rx_data;
                    idx_nx  = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_nx   = cnt_inc;
                state_nx = (cnt_inc == len_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        done_nx = 1'b1;
                        crst_nx = 1'b0;
                    end else begin
                        err_nx = 1'b1;
                    end
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Inter-byte watchdog; an accepted byte in the expiry cycle wins.
        if (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM) begin
            if (accept) begin
                tmo_nx = '0;
            end else if (tmo_q == TMO_LAST) begin
                err_nx   = 1'b1;
                state_nx = S_IDLE;
            end else begin
                tmo_nx = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= 2'd0;
            word_q  <= 32'd0;
            csum_q  <= 8'd0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            crst_q  <= BOOT_HOLD;
        end else begin
            state_q <= state_nx;
            len_q   <= len_nx;
            idx_q   <= idx_nx;
            word_q  <= word_nx;
            csum_q  <= csum_nx;
            tmo_q   <= tmo_nx;
            cnt_q   <= cnt_nx;
            err_q   <= err_nx;
            done_q  <= done_nx;
            crst_q  <= crst_nx;
        end
    end

endmodule

// File: tb/tb_mm_prog_loader.sv
// Bench for mm_prog_loader: directed frames from the test plan plus random frames,
// all checked against a frame-level reference model.
module tb_mm_prog_loader;

    localparam int         DEPTH     = 128;
    localparam int         ADDR_W    = 7;
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam int         TIMEOUT   = 1024;
    localparam bit         BOOT_HOLD = 1'b0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready, mem_we, core_rst, load_busy, load_done, load_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   word_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mm_prog_loader #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC(SYNC), .TIMEOUT(TIMEOUT), .BOOT_HOLD(BOOT_HOLD)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst(core_rst),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err), .word_cnt(word_cnt)
    );

    logic [ADDR_W+31:0] obs_w[$];
    logic [ADDR_W+31:0] exp_w[$];
    logic [7:0]         frm[$];
    int   obs_done;
    int   exp_done;
    int   exp_wc;
    int   ready_viol = 0;
    logic exp_err;
    logic m_crst = BOOT_HOLD;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we === 1'b1) obs_w.push_back({mem_addr, mem_wdata});
            if (load_done === 1'b1) obs_done++;
            if (rx_ready !== ~mem_we) ready_viol++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_w.delete();
        obs_done = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        while (rx_ready !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL rx_ready_bound: rx_ready=%b after %0d cycles, required 1", rx_ready, guard);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_all(input int gap_max);
        foreach (frm[i]) begin
            send_byte(frm[i]);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
        idle(3);
    endtask

    // Frame-level model: locate SYNC, apply the length rule, slice payload into
    // little-endian words and compare the payload sum with the trailing byte.
    function automatic void model(input logic [7:0] q[$]);
        int s = 0;
        int len;
        logic [7:0] sum = 8'd0;
        exp_w.delete();
        exp_done = 0;
        while (s < q.size() && q[s] != SYNC) s++;
        if (s >= q.size()) return;
        len = int'(q[s+1]);
        exp_wc = 0;
        if (len == 0 || len > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < len; w++) begin
            int b = s + 2 + 4*w;
            exp_w.push_back({ADDR_W'(w), q[b+3], q[b+2], q[b+1], q[b]});
            sum = sum + q[b] + q[b+1] + q[b+2] + q[b+3];
        end
        exp_wc = len;
        if (sum == q[s + 2 + 4*len]) begin
            exp_done = 1; exp_err = 1'b0; m_crst = 1'b0;
        end else begin
            exp_err = 1'b1; m_crst = 1'b1;
        end
    endfunction

    task automatic build_frame(input int len, input bit bad, input int junk);
        logic [7:0] sum = 8'd0;
        logic [7:0] b;
        frm.delete();
        repeat (junk) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h00;
            frm.push_back(b);
        end
        frm.push_back(SYNC);
        frm.push_back(8'(len));
        for (int i = 0; i < 4*len; i++) begin
            b = 8'($urandom_range(0, 255));
            frm.push_back(b);
            sum = sum + b;
        end
        frm.push_back(bad ? sum + 8'(1 + $urandom_range(0, 254)) : sum);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        n_tests++;
        if ({rx_ready, mem_we, mem_addr, mem_wdata, core_rst, load_busy, load_done, load_err, word_cnt}
            !== {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'd0, BOOT_HOLD, 1'b0, 1'b0, 1'b0, {(ADDR_W+1){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%0h wd=%0h crst=%b busy=%b done=%b err=%b wc=%0d, required 1 0 0 0 %b 0 0 0 0",
                     rx_ready, mem_we, mem_addr, mem_wdata, core_rst, load_busy, load_done, load_err, word_cnt, BOOT_HOLD);
        end
    endtask

    task automatic test_good_frame();
        frm = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        model(frm);
        clear_obs();
        foreach (frm[i]) begin
            send_byte(frm[i]);
            if (i == 1) begin
                n_tests++;
                if (core_rst !== 1'b1 || load_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL good_hold: core_rst=%b busy=%b, required 1 1", core_rst, load_busy);
                end
            end
            if (i == 5 || i == 9) begin
                n_tests++;
                if (rx_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== ADDR_W'((i - 5) / 4)) begin
                    n_fail++;
                    $display("FAIL good_write_slot: byte %0d rdy=%b we=%b addr=%0d, required 0 1 %0d",
                             i, rx_ready, mem_we, mem_addr, (i - 5) / 4);
                end
            end
        end
        idle(3);
        n_tests++;
        if (obs_w.size() != exp_w.size()) begin
            n_fail++;
            $display("FAIL good_nwrites: got %0d, required %0d", obs_w.size(), exp_w.size());
        end else foreach (exp_w[k]) if (obs_w[k] !== exp_w[k]) begin
            n_fail++;
            $display("FAIL good_write%0d: got %h, required %h", k, obs_w[k], exp_w[k]);
        end
        n_tests++;
        if (obs_done !== exp_done || load_err !== exp_err || core_rst !== m_crst || word_cnt !== (ADDR_W+1)'(exp_wc)) begin
            n_fail++;
            $display("FAIL good_status: done=%0d err=%b crst=%b wc=%0d, required %0d %b %b %0d",
                     obs_done, load_err, core_rst, word_cnt, exp_done, exp_err, m_crst, exp_wc);
        end
    endtask

    task automatic test_bad_csum();
        frm = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
        model(frm);
        clear_obs();
        send_all(0);
        n_tests++;
        if (obs_w.size() != exp_w.size()) begin
            n_fail++;
            $display("FAIL badcs_nwrites: got %0d, required %0d", obs_w.size(), exp_w.size());
        end else foreach (exp_w[k]) if (obs_w[k] !== exp_w[k]) begin
            n_fail++;
            $display("FAIL badcs_write%0d: got %h, required %h", k, obs_w[k], exp_w[k]);
        end
        n_tests++;
        if (obs_done !== exp_done || load_err !== exp_err || core_rst !== m_crst) begin
            n_fail++;
            $display("FAIL badcs_status: done=%0d err=%b crst=%b, required %0d %b %b",
                     obs_done, load_err, core_rst, exp_done, exp_err, m_crst);
        end
        build_frame(1, 1'b0, 0);
        model(frm);
        clear_obs();
        send_byte(frm[0]);
        n_tests++;
        if (load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL badcs_err_clear: load_err=%b after SYNC, required 0", load_err);
        end
        frm.delete(0);
        send_all(0);
        n_tests++;
        if (obs_done !== exp_done || load_err !== exp_err || core_rst !== m_crst || obs_w.size() != 1) begin
            n_fail++;
            $display("FAIL badcs_recover: done=%0d err=%b crst=%b nw=%0d, required %0d %b %b 1",
                     obs_done, load_err, core_rst, obs_w.size(), exp_done, exp_err, m_crst);
        end
    endtask

    task automatic test_bad_len();
        logic [7:0] lens[2] = '{8'h00, 8'h81};
        for (int j = 0; j < 2; j++) begin
            frm = {SYNC, lens[j]};
            model(frm);
            clear_obs();
            send_all(0);
            n_tests++;
            if (load_err !== exp_err || load_busy !== 1'b0 || obs_w.size() != 0 || core_rst !== m_crst
                || word_cnt !== (ADDR_W+1)'(exp_wc)) begin
                n_fail++;
                $display("FAIL badlen_%0h: err=%b busy=%b nw=%0d crst=%b wc=%0d, required %b 0 0 %b %0d",
                         lens[j], load_err, load_busy, obs_w.size(), core_rst, word_cnt, exp_err, m_crst, exp_wc);
            end
        end
        send_byte(8'h11);
        n_tests++;
        if (load_busy !== 1'b0 || load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL badlen_discard: busy=%b err=%b, required 0 1", load_busy, load_err);
        end
    endtask

    task automatic test_timeout();
        frm = {SYNC, 8'h01, 8'h11, 8'h22};
        foreach (frm[i]) send_byte(frm[i]);
        idle(TIMEOUT - 1);
        n_tests++;
        if (load_err !== 1'b0 || load_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_early: err=%b busy=%b at cycle %0d, required 0 1", load_err, load_busy, TIMEOUT - 1);
        end
        idle(1);
        m_crst = 1'b1;
        n_tests++;
        if (load_err !== 1'b1 || load_busy !== 1'b0 || core_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_expire: err=%b busy=%b crst=%b, required 1 0 1", load_err, load_busy, core_rst);
        end
        frm = {SYNC, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        model(frm);
        clear_obs();
        for (int i = 0; i < 4; i++) send_byte(frm[i]);
        idle(TIMEOUT - 1);
        send_byte(frm[4]);
        n_tests++;
        if (load_err !== 1'b0 || load_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_byte_wins: err=%b busy=%b, required 0 1", load_err, load_busy);
        end
        send_byte(frm[5]);
        send_byte(frm[6]);
        idle(3);
        n_tests++;
        if (obs_done !== exp_done || load_err !== exp_err || core_rst !== m_crst
            || obs_w.size() != 1 || obs_w[0] !== exp_w[0]) begin
            n_fail++;
            $display("FAIL tmo_finish: done=%0d err=%b crst=%b nw=%0d, required %0d %b %b 1",
                     obs_done, load_err, core_rst, obs_w.size(), exp_done, exp_err, m_crst);
        end
    endtask

    task automatic test_sync_hunt();
        frm = {8'h00, 8'hFF, 8'h5A, SYNC, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h1E};
        model(frm);
        clear_obs();
        send_all(0);
        n_tests++;
        if (obs_w.size() != 1 || obs_w[0] !== exp_w[0]) begin
            n_fail++;
            $display("FAIL hunt_write: nw=%0d first=%h, required 1 %h", obs_w.size(),
                     (obs_w.size() > 0) ? obs_w[0] : '0, exp_w[0]);
        end
        n_tests++;
        if (obs_done !== exp_done || load_err !== exp_err || core_rst !== m_crst) begin
            n_fail++;
            $display("FAIL hunt_status: done=%0d err=%b crst=%b, required %0d %b %b",
                     obs_done, load_err, core_rst, exp_done, exp_err, m_crst);
        end
    endtask

    task automatic test_reset_mid_load();
        frm = {SYNC, 8'h02, 8'h11, 8'h22};
        foreach (frm[i]) send_byte(frm[i]);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        m_crst = BOOT_HOLD;
        n_tests++;
        if ({rx_ready, mem_we, mem_addr, mem_wdata, core_rst, load_busy, load_done, load_err, word_cnt}
            !== {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'd0, BOOT_HOLD, 1'b0, 1'b0, 1'b0, {(ADDR_W+1){1'b0}}}) begin
            n_fail++;
            $display("FAIL midrst_values: rdy=%b we=%b addr=%0h wd=%0h crst=%b busy=%b err=%b wc=%0d, required 1 0 0 0 %b 0 0 0",
                     rx_ready, mem_we, mem_addr, mem_wdata, core_rst, load_busy, load_err, word_cnt, BOOT_HOLD);
        end
        build_frame(3, 1'b0, 0);
        model(frm);
        clear_obs();
        send_all(0);
        n_tests++;
        if (obs_w.size() != exp_w.size()) begin
            n_fail++;
            $display("FAIL midrst_nwrites: got %0d, required %0d", obs_w.size(), exp_w.size());
        end else foreach (exp_w[k]) if (obs_w[k] !== exp_w[k]) begin
            n_fail++;
            $display("FAIL midrst_write%0d: got %h, required %h", k, obs_w[k], exp_w[k]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int kind = $urandom_range(0, 7);
            if (it == 0) build_frame(DEPTH, 1'b0, 1);
            else if (kind == 0) begin
                frm = {SYNC, 8'($urandom_range(DEPTH + 1, 255))};
                if ($urandom_range(0, 1) == 0) frm[1] = 8'h00;
            end
            else build_frame($urandom_range(1, 6), kind == 1 || kind == 2, $urandom_range(0, 3));
            model(frm);
            clear_obs();
            send_all(2);
            n_tests++;
            if (obs_w.size() != exp_w.size()) begin
                n_fail++;
                $display("FAIL rand%0d_nwrites: got %0d, required %0d", it, obs_w.size(), exp_w.size());
            end else foreach (exp_w[k]) if (obs_w[k] !== exp_w[k]) begin
                n_fail++;
                $display("FAIL rand%0d_write%0d: got %h, required %h", it, k, obs_w[k], exp_w[k]);
            end
            n_tests++;
            if (obs_done !== exp_done || load_err !== exp_err || core_rst !== m_crst
                || word_cnt !== (ADDR_W+1)'(exp_wc) || load_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_status: done=%0d err=%b crst=%b wc=%0d busy=%b, required %0d %b %b %0d 0",
                         it, obs_done, load_err, core_rst, word_cnt, load_busy, exp_done, exp_err, m_crst, exp_wc);
            end
        end
        n_tests++;
        if (ready_viol != 0) begin
            n_fail++;
            $display("FAIL ready_vs_write: %0d cycles with rx_ready not the inverse of mem_we, required 0", ready_viol);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_timeout();
        test_sync_hunt();
        test_reset_mid_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
